prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the CPU instruction-fetch interface. It receives a program image over a UART
//  RX line and writes it word by word into the instruction memory that the CPU reads via
//  inst_addr/inst. It holds the CPU in reset while a load is in progress and releases it only
//  after the frame's checksum has been verified. It sits beside the CPU in the FPGA top level.
// PARAMETERS
//  CLKS_PER_BIT  434     clk cycles per UART bit (50 MHz / 115200)
//  ADDR_W        15      instruction address width; matches CPU inst_addr
//  TIMEOUT_CYC   500000  max idle clk cycles between bytes inside a frame
// PORTS
//  clk         in   1       clock
//  nrst        in   1       reset, synchronous, active-low
//  rx          in   1       UART RX, async; idle high; 8N1, LSB first
//  prog_we     out  1       1-cycle instruction-memory write strobe
//  prog_addr   out  ADDR_W  write address
//  prog_wdata  out  16      write data
//  cpu_nrst    out  1       registered synchronous reset to CPU; 0 = hold
//  busy        out  1       frame in progress
//  done        out  1       sticky: last frame loaded OK
//  err         out  1       sticky: last frame failed (checksum, timeout, length, framing)
// BEHAVIOUR
//  Reset values:
//   - prog_we=0, prog_addr=0, prog_wdata=0, busy=0, done=0, err=0, cpu_nrst=0.
//   - cpu_nrst goes to 1 on the first clk edge with nrst=1 (CPU runs its existing image).
//  Frame format:
//   - SYNC 0xA5, LEN_HI, LEN_LO, N words (hi byte first), CHK.
//   - N = {LEN_HI,LEN_LO}; CHK = XOR of every byte after SYNC.
//  UART RX:
//   - rx passes through a 2-FF synchronizer.
//   - A start bit is a falling edge that is still low at the half-bit.
//   - Data bits are sampled at mid-bit; the stop bit must be 1, else the byte is discarded
//     as a framing error.
//  FSM states and transitions:
//   - IDLE: waits for byte 0xA5; all other bytes are ignored. On 0xA5: clear done and err,
//     set busy, set cpu_nrst=0 on the next edge, clear the word counter and running XOR,
//     go to LEN_H.
//   - LEN_H -> LEN_L. After LEN_L:
//     - N > 2^ADDR_W -> FAIL.
//     - N = 0 -> CHK.
//     - else -> DAT_H.
//   - DAT_H -> DAT_L. When the low byte arrives:
//     - prog_we=1 for exactly 1 cycle, with prog_wdata={hi,lo} and prog_addr=word counter.
//     - The counter then increments.
//     - After word N-1 -> CHK, else -> DAT_H.
//   - CHK: byte == running XOR -> OK, else -> FAIL.
//   - OK (1 cycle): done=1, busy=0, cpu_nrst=1 on the next edge, go to IDLE. The CPU
//     restarts from pc 0.
//   - FAIL (1 cycle): err=1, busy=0, cpu_nrst stays 0, go to IDLE. Only a new good frame or
//     nrst releases the CPU.
//  Boundary conditions:
//   - Timeout: in any state other than IDLE, a gap of TIMEOUT_CYC cycles without a byte
//     -> FAIL. The counter resets on each received byte.
//   - Framing error inside a frame -> FAIL. In IDLE it is ignored.
//   - 0xA5 inside a frame is data, not a resync.
//   - Words already written before a FAIL are not rolled back.
//   - The address counter never wraps: N is bounded by the length check, so the last write
//     is at 2^ADDR_W-1.
//   - nrst low mid-frame: immediate return to reset values, FSM to IDLE, and any partial
//     UART byte is dropped.
//  Latency: prog_we fires within 2 clk of the mid-stop-bit sample of a low data byte.
// STRUCTURE
//  - Shared header loader_defs.vh: SYNC_BYTE=8'hA5, the FSM state encodings, the default
//    CLKS_PER_BIT.
//  - One sub-module: uart_rx. It contains the synchronizer, the bit-timing counter and the
//    shift register. Outputs: rx_valid (1-cycle pulse), rx_data[7:0], rx_ferr.
//  - prog_loader contains the frame FSM, the length/word/XOR registers and the timeout
//    counter.
// TESTING (bench: CLKS_PER_BIT=8, TIMEOUT_CYC=400, 64-word memory model)
//  1. Reset -> all outputs 0 while nrst=0. First edge with nrst=1 -> cpu_nrst=1.
//  2. Send A5 00 02 12 34 AB CD CHK=0x02^0x12^0x34^0xAB^0xCD (=0x42)
//     -> writes mem[0]=0x1234 and mem[1]=0xABCD, one prog_we pulse each.
//     -> done=1, cpu_nrst returns to 1.
//  3. Same frame with CHK=0x00 -> mem written, err=1, done=0, cpu_nrst stays 0.
//     A subsequent good frame -> err=0, done=1, cpu_nrst=1.
//  4. A5 00 03 then 1 word, then silence for 400 cycles -> err=1, busy=0, FSM in IDLE.
//     Exactly 1 prog_we pulse seen.
//  5. Bytes 0x00 0xFF then a byte with a bad stop bit, all in IDLE -> no state change.
//     A5 00 00 00 -> done=1 with 0 writes.
//  6. nrst pulsed low after the 3rd data byte -> outputs return to reset values.
//     The next full frame loads correctly starting from prog_addr=0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and state encodings for the program loader
package prog_loader_pkg;
  localparam logic [7:0] SYNC_BYTE        = 8'hA5;
  localparam int         DEF_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN_H, ST_LEN_L, ST_DAT_H, ST_DAT_L, ST_CHK, ST_OK, ST_FAIL
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;
endpackage

// File: rtl/prog_loader_uart_rx.sv
// rtl/prog_loader_uart_rx.sv - 8N1 UART receiver with synchronizer and mid-bit sampling
module prog_loader_uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);
  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state, w_next;
  logic [1:0]    r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid, r_ferr;
  logic          w_rx, w_half, w_full;

  assign w_rx     = r_sync[1];
  assign w_half   = (r_cnt == HALF);
  assign w_full   = (r_cnt == FULL);
  assign rx_valid = r_valid;
  assign rx_data  = r_data;
  assign rx_ferr  = r_ferr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (r_prev && !w_rx) w_next = RX_START;
      RX_START: if (w_half) w_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && r_bit == 3'd7) w_next = RX_STOP;
      default:  if (w_full) w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= RX_IDLE;
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[0], rx};
      r_prev  <= w_rx;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
        end
        RX_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
        RX_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (w_full) begin
            r_cnt <= '0;
            // a low stop bit discards the byte
            if (w_rx) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a checksummed UART program frame into instruction memory
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADDR_W       = 15,
  parameter int TIMEOUT_CYC  = 500000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              rx,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [15:0]       prog_wdata,
  output logic              cpu_nrst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int            LW       = 17;
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LW-1:0] MAX_N    = LW'(2 ** ADDR_W);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  ld_state_t         r_state, w_next;
  logic [7:0]        r_len_hi, r_hi, r_xor;
  logic [15:0]       r_len;
  logic [ADDR_W-1:0] r_wcnt;
  logic [TW-1:0]     r_tmo;
  logic              r_hold, w_hold;
  logic              r_prog_we, r_cpu_nrst, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_prog_addr;
  logic [15:0]       r_prog_wdata;
  logic              w_rx_valid, w_rx_ferr;
  logic [7:0]        w_rx_data;
  logic [15:0]       w_len;
  logic              w_in_frame, w_sync, w_tmo, w_last;

  prog_loader_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .nrst     (nrst),
    .rx       (rx),
    .rx_valid (w_rx_valid),
    .rx_data  (w_rx_data),
    .rx_ferr  (w_rx_ferr)
  );

  assign w_len      = {r_len_hi, w_rx_data};
  assign w_in_frame = (r_state != ST_IDLE) && (r_state != ST_OK) && (r_state != ST_FAIL);
  assign w_sync     = (r_state == ST_IDLE) && w_rx_valid && (w_rx_data == SYNC_BYTE);
  assign w_tmo      = (r_tmo == TMO_LAST);
  assign w_last     = (LW'(r_wcnt) + LW'(1)) == {1'b0, r_len};

  assign prog_we    = r_prog_we;
  assign prog_addr  = r_prog_addr;
  assign prog_wdata = r_prog_wdata;
  assign cpu_nrst   = r_cpu_nrst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

  always_comb begin
    w_next = r_state;
    w_hold = r_hold;
    case (r_state)
      ST_IDLE:  if (w_sync) w_next = ST_LEN_H;
      ST_LEN_H: if (w_rx_valid) w_next = ST_LEN_L;
      ST_LEN_L: begin
        if (w_rx_valid) begin
          if ({1'b0, w_len} > MAX_N) w_next = ST_FAIL;
          else if (w_len == 16'd0)   w_next = ST_CHK;
          else                       w_next = ST_DAT_H;
        end
      end
      ST_DAT_H: if (w_rx_valid) w_next = ST_DAT_L;
      ST_DAT_L: if (w_rx_valid) w_next = w_last ? ST_CHK : ST_DAT_H;
      ST_CHK:   if (w_rx_valid) w_next = (w_rx_data == r_xor) ? ST_OK : ST_FAIL;
      default:  w_next = ST_IDLE;
    endcase
    if (w_in_frame && (w_rx_ferr || w_tmo)) w_next = ST_FAIL;
    // the CPU stays held after a failed frame until a good one completes
    if (w_sync)                  w_hold = 1'b1;
    else if (r_state == ST_OK)   w_hold = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_len_hi     <= '0;
      r_hi         <= '0;
      r_xor        <= '0;
      r_len        <= '0;
      r_wcnt       <= '0;
      r_tmo        <= '0;
      r_hold       <= 1'b0;
      r_prog_we    <= 1'b0;
      r_prog_addr  <= '0;
      r_prog_wdata <= '0;
      r_cpu_nrst   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_hold     <= w_hold;
      r_cpu_nrst <= !w_hold;
      r_prog_we  <= 1'b0;
      if (w_in_frame) r_tmo <= w_rx_valid ? '0 : r_tmo + 1'b1;
      else            r_tmo <= '0;
      if (w_in_frame && w_rx_valid) r_xor <= r_xor ^ w_rx_data;
      case (r_state)
        ST_IDLE: begin
          if (w_sync) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            r_wcnt <= '0;
            r_xor  <= '0;
          end
        end
        ST_LEN_H: if (w_rx_valid) r_len_hi <= w_rx_data;
        ST_LEN_L: if (w_rx_valid) r_len <= w_len;
        ST_DAT_H: if (w_rx_valid) r_hi <= w_rx_data;
        ST_DAT_L: begin
          if (w_rx_valid) begin
            r_prog_we    <= 1'b1;
            r_prog_addr  <= r_wcnt;
            r_prog_wdata <= {r_hi, w_rx_data};
            r_wcnt       <= r_wcnt + 1'b1;
          end
        end
        ST_OK: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        ST_FAIL: begin
          r_err  <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader with write scoreboard
module tb_prog_loader;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rx = 1'b1;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic        cpu_nrst, busy, done, err;

  typedef struct packed { logic [5:0] addr; logic [15:0] data; } wr_t;
  typedef struct {
    int n; logic [15:0] w0, w1, w2; logic [7:0] chk; logic done_e; logic err_e;
  } vec_t;

  wr_t         sb_q[$];
  logic [15:0] mem [64];
  logic [15:0] g_words [64];
  vec_t        vecs [5];
  int          checks = 0;
  int          errors = 0;
  int          n_writes = 0;
  int          w_before;

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(6), .TIMEOUT_CYC(400)) dut (
    .clk(clk), .nrst(nrst), .rx(rx), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .cpu_nrst(cpu_nrst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (prog_we) begin
      n_writes++;
      mem[prog_addr] = prog_wdata;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", prog_addr, prog_wdata);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(prog_addr), 32'(e.addr));
        check("wr_data", 32'(prog_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] calc_chk(input int n);
    logic [15:0] nn;
    logic [7:0]  x;
    nn = 16'(n);
    x  = nn[15:8] ^ nn[7:0];
    for (int i = 0; i < n; i++) x = x ^ g_words[i][15:8] ^ g_words[i][7:0];
    return x;
  endfunction

  task automatic send_frame(input int n, input logic [7:0] chk);
    logic [15:0] nn;
    nn = 16'(n);
    send_byte(8'hA5);
    check("busy_mid", 32'(busy), 32'd1);
    check("cpu_hold_mid", 32'(cpu_nrst), 32'd0);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({6'(i), g_words[i]});
      send_byte(g_words[i][15:8]);
      send_byte(g_words[i][7:0]);
    end
    send_byte(chk);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_end(input string tag, input logic d, input logic e);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cpu_nrst"}, 32'(cpu_nrst), 32'(d));
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2, 16'h1234, 16'hABCD, 16'h0000, 8'h42, 1'b1, 1'b0};
    vecs[1] = '{2, 16'h1234, 16'hABCD, 16'h0000, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{3, 16'h0001, 16'hA5A5, 16'hFFFF, 8'h02, 1'b1, 1'b0};
    vecs[3] = '{0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{1, 16'h00A5, 16'h0000, 16'h0000, 8'hA4, 1'b1, 1'b0};

    repeat (5) @(negedge clk);
    check("rst_we", 32'(prog_we), 32'd0);
    check("rst_addr", 32'(prog_addr), 32'd0);
    check("rst_wdata", 32'(prog_wdata), 32'd0);
    check("rst_cpu_nrst", 32'(cpu_nrst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_cpu_nrst", 32'(cpu_nrst), 32'd1);
    repeat (4) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      g_words[0] = vecs[v].w0;
      g_words[1] = vecs[v].w1;
      g_words[2] = vecs[v].w2;
      w_before = n_writes;
      send_frame(vecs[v].n, vecs[v].chk);
      check_end($sformatf("vec%0d", v), vecs[v].done_e, vecs[v].err_e);
      check($sformatf("vec%0d_nwr", v), 32'(n_writes - w_before), 32'(vecs[v].n));
    end

    // timeout: one word of a three-word frame, then silence
    w_before = n_writes;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    sb_q.push_back({6'd0, 16'h1234});
    send_byte(8'h12); send_byte(8'h34);
    repeat (300) @(negedge clk);
    check("tmo_pending_err", 32'(err), 32'd0);
    check("tmo_pending_busy", 32'(busy), 32'd1);
    repeat (200) @(negedge clk);
    check_end("tmo", 1'b0, 1'b1);
    check("tmo_nwr", 32'(n_writes - w_before), 32'd1);

    // idle junk and an idle framing error change nothing
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    check_end("idle_junk", 1'b0, 1'b1);
    check("idle_nwr", 32'(n_writes - w_before), 32'd1);
    send_frame(0, 8'h00);
    check_end("empty", 1'b1, 1'b0);

    // length one beyond the memory size
    w_before = n_writes;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h41);
    repeat (4) @(negedge clk);
    check_end("len_ovf", 1'b0, 1'b1);
    check("len_ovf_nwr", 32'(n_writes - w_before), 32'd0);

    // framing error inside a frame
    send_frame(0, 8'h00);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12, 1'b0);
    repeat (4) @(negedge clk);
    check_end("frm_err", 1'b0, 1'b1);

    // full memory: last write at address 63
    for (int i = 0; i < 64; i++) g_words[i] = {8'(i), 8'(~i)};
    w_before = n_writes;
    send_frame(64, calc_chk(64));
    check_end("full", 1'b1, 1'b0);
    check("full_nwr", 32'(n_writes - w_before), 32'd64);
    check("full_mem63", 32'(mem[63]), 32'h3FC0);

    // reset mid-frame after the third data byte
    sb_q.push_back({6'd0, 16'h1122});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_we", 32'(prog_we), 32'd0);
    check("mrst_addr", 32'(prog_addr), 32'd0);
    check("mrst_wdata", 32'(prog_wdata), 32'd0);
    check("mrst_cpu_nrst", 32'(cpu_nrst), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_rel_cpu", 32'(cpu_nrst), 32'd1);
    repeat (4) @(negedge clk);
    g_words[0] = 16'hCAFE;
    g_words[1] = 16'hBEEF;
    send_frame(2, calc_chk(2));
    check_end("after_rst", 1'b1, 1'b0);
    check("after_rst_mem0", 32'(mem[0]), 32'hCAFE);
    check("after_rst_mem1", 32'(mem[1]), 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
